fetch_stage: RTL and testbench
==============================

Name: fetch_stage

Overview:
- IF stage plus IF/ID pipeline register of the 5-stage MIPS pipeline.
- Owns the PC and drives the instruction-memory address; imem read is combinational.
- Latches the fetched word and PC+4 into IF/ID, which feeds the ID-stage main decoder (op field) and the register file.
- Applies load-use stalls, jump redirects (resolved in ID) and taken-branch redirects (resolved in EX). No delay slot: every redirect squashes wrong-path fetches.

Parameters:
- RESET_PC, 32'h0000_3000, PC value after reset.
- NOP_WORD, 32'h0000_0000, instruction word loaded into IF/ID on squash/reset.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- stall  input  1  load-use hazard from hazard unit: hold PC and IF/ID.
- jump  input  1  ID-stage decoder Jump for the instruction currently in IF/ID.
- jump_index  input  26  ifid_instr[25:0] as seen by ID.
- branch_taken  input  1  EX-stage beq resolved taken.
- branch_target  input  32  EX-stage branch target address.
- imem_addr  output  32  current PC to instruction memory.
- imem_data  input  32  instruction word at imem_addr, same cycle.
- ifid_instr  output  32  registered instruction.
- ifid_pc4  output  32  registered PC+4 of ifid_instr.
- ifid_valid  output  1  1 = ifid_instr is a real, non-squashed instruction.
- op  output  6  ifid_instr[31:26], to decoder.
- flush_idex  output  1  combinational, = branch_taken: ID/EX must load a bubble.
- fetch_count  output  32  count of instructions delivered valid into IF/ID.

Behaviour:
- Reset, asynchronous, any time including mid-stall or mid-redirect:
  - pc=RESET_PC, ifid_instr=NOP_WORD, ifid_pc4=0, ifid_valid=0, fetch_count=0.
  - On release, the first edge loads imem_data@RESET_PC with valid=1.
- imem_addr = pc, combinational. pc[1:0] is always 00.
- Per rising edge, first matching case wins:
  1. branch_taken:
     - pc <= {branch_target[31:2],2'b00}.
     - IF/ID <= NOP_WORD, pc4=0, valid=0.
     - Overrides stall and jump; the instruction in ID is squashed via flush_idex.
  2. stall:
     - pc, ifid_instr, ifid_pc4, ifid_valid all hold; fetch_count holds.
     - A jump in ID is re-presented next cycle.
  3. jump & ifid_valid:
     - pc <= {ifid_pc4[31:28], jump_index, 2'b00}.
     - IF/ID <= bubble (valid=0); the sequential fetch is discarded.
  4. Otherwise:
     - pc <= pc+4, modulo 2^32 (wraps 32'hFFFF_FFFC -> 0).
     - IF/ID <= {imem_data, pc+4}, valid=1.
     - fetch_count += 1 (wraps).
- jump while ifid_valid=0 is ignored.
- Latency:
  - Instruction reaches ID 1 cycle after its PC is presented.
  - Taken branch costs 2 bubbles (IF/ID + ID/EX); jump costs 1.
- op is a pure slice of ifid_instr; it is 000000 (rtype decode of NOP) when squashed. Downstream must gate RegWr/MemWr with ifid_valid.

Test Plan:
- Reset with RESET_PC=32'h3000; imem[3000]=34010005, imem[3004]=8C220000.
  - Edge1: ifid_instr=34010005, pc4=3004, op=001101, valid=1.
  - Edge2: ifid_instr=8C220000, imem_addr=3008, fetch_count=2.
- stall high 2 cycles with ifid_instr=8C220000, pc=3008.
  - pc, IF/ID and fetch_count unchanged for both cycles.
  - Next edge after release loads imem[3008].
- IF/ID holds 08000C10 (pc4=3010), jump=1, jump_index=0000C10.
  - Next: pc=3040, valid=0.
  - Following edge: ifid_instr=imem[3040], ifid_pc4=3044.
- branch_taken=1, branch_target=32'h3100, same cycle as stall=1 and jump=1.
  - flush_idex=1 that cycle.
  - pc=3100 and valid=0 after the edge; stall and jump ignored.
- Assert reset asynchronously mid-cycle while pc=3020 and stall=1.
  - Outputs go to reset values immediately, before any clock edge.
  - After release, fetch resumes at 3000.
- Force pc to FFFFFFFC via branch_target.
  - Next sequential fetch gives ifid_pc4=00000000 and imem_addr=00000000.

Source files
------------

// File: rtl/fetch_stage.sv
// -----------------------------------------------------------------------------
// fetch_stage
//   Instruction-fetch stage and IF/ID pipeline register for a 5-stage MIPS
//   pipeline. Owns the PC, presents it to a combinational instruction memory,
//   and latches the returned word together with PC+4 into IF/ID.
//   Handles load-use stalls, ID-resolved jumps and EX-resolved taken branches.
//   There is no delay slot: every redirect squashes the wrong-path fetch.
//
// Ports
//   clk            rising-edge clock
//   reset          asynchronous, active-high reset
//   stall          hold PC and IF/ID (load-use hazard)
//   jump           ID decoder Jump for the instruction in IF/ID
//   jump_index     instr[25:0] of the jump in ID
//   branch_taken   EX beq resolved taken
//   branch_target  EX branch target address
//   imem_addr      PC to instruction memory
//   imem_data      instruction word at imem_addr (same cycle)
//   ifid_instr     registered instruction
//   ifid_pc4       registered PC+4 of ifid_instr
//   ifid_valid     1 = ifid_instr is a real, non-squashed instruction
//   op             ifid_instr[31:26]
//   flush_idex     = branch_taken, ID/EX must load a bubble
//   fetch_count    number of instructions delivered valid into IF/ID
// -----------------------------------------------------------------------------
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000,
  parameter logic [31:0] NOP_WORD = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        jump,
  input  logic [25:0] jump_index,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_data,
  output logic [31:0] ifid_instr,
  output logic [31:0] ifid_pc4,
  output logic        ifid_valid,
  output logic [5:0]  op,
  output logic        flush_idex,
  output logic [31:0] fetch_count
);

  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] pc4_q, pc4_d;
  logic        valid_q, valid_d;
  logic [31:0] count_q, count_d;
  logic [31:0] pc_plus4;

  assign pc_plus4 = pc_q + 32'd4;

  // Priority: taken branch > stall > jump (only if IF/ID is valid) > sequential.
  always_comb begin
    pc_d    = pc_q;
    instr_d = instr_q;
    pc4_d   = pc4_q;
    valid_d = valid_q;
    count_d = count_q;
    if (branch_taken) begin
      // Low address bits are forced to zero so the PC stays word aligned.
      pc_d    = branch_target & 32'hFFFF_FFFC;
      instr_d = NOP_WORD;
      pc4_d   = 32'd0;
      valid_d = 1'b0;
    end else if (stall) begin
      // Everything holds; a pending jump is re-presented by ID next cycle.
    end else if (jump && valid_q) begin
      pc_d    = {pc4_q[31:28], jump_index, 2'b00};
      instr_d = NOP_WORD;
      pc4_d   = 32'd0;
      valid_d = 1'b0;
    end else begin
      pc_d    = pc_plus4;
      instr_d = imem_data;
      pc4_d   = pc_plus4;
      valid_d = 1'b1;
      count_d = count_q + 32'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q    <= RESET_PC;
      instr_q <= NOP_WORD;
      pc4_q   <= 32'd0;
      valid_q <= 1'b0;
      count_q <= 32'd0;
    end else begin
      pc_q    <= pc_d;
      instr_q <= instr_d;
      pc4_q   <= pc4_d;
      valid_q <= valid_d;
      count_q <= count_d;
    end
  end

  assign imem_addr   = pc_q;
  assign ifid_instr  = instr_q;
  assign ifid_pc4    = pc4_q;
  assign ifid_valid  = valid_q;
  assign op          = instr_q[31:26];
  assign flush_idex  = branch_taken;
  assign fetch_count = count_q;

endmodule

// File: tb/tb_fetch_stage.sv
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall;
  logic        jump;
  logic [25:0] jump_index;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic [31:0] imem_addr;
  logic [31:0] imem_data;
  logic [31:0] ifid_instr;
  logic [31:0] ifid_pc4;
  logic        ifid_valid;
  logic [5:0]  op;
  logic        flush_idex;
  logic [31:0] fetch_count;

  int n_checks = 0;
  int n_pass   = 0;

  fetch_stage #(.RESET_PC(32'h0000_3000), .NOP_WORD(32'h0000_0000)) dut (
    .clk(clk), .reset(reset), .stall(stall), .jump(jump),
    .jump_index(jump_index), .branch_taken(branch_taken),
    .branch_target(branch_target), .imem_addr(imem_addr),
    .imem_data(imem_data), .ifid_instr(ifid_instr), .ifid_pc4(ifid_pc4),
    .ifid_valid(ifid_valid), .op(op), .flush_idex(flush_idex),
    .fetch_count(fetch_count)
  );

  always #5 clk = ~clk;

  // Instruction memory contents: a few fixed words, a hash everywhere else.
  function automatic logic [31:0] mem_f(input logic [31:0] a);
    case (a)
      32'h0000_3000: return 32'h3401_0005;
      32'h0000_3004: return 32'h8C22_0000;
      32'h0000_300C: return 32'h0800_0C10;
      default:       return (a * 32'h9E37_79B1) ^ {a[15:0], a[31:16]};
    endcase
  endfunction

  always_comb imem_data = mem_f(imem_addr);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
  endtask

  // Reference model: architectural fetch state advanced once per edge
  // using the priority rules branch > stall > jump > sequential.
  logic [31:0] m_pc, m_instr, m_pc4, m_count;
  logic        m_valid;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_pc = 32'h3000; m_instr = 0; m_pc4 = 0; m_valid = 0; m_count = 0;
    end else if (branch_taken) begin
      m_pc = {branch_target[31:2], 2'b00};
      m_instr = 0; m_pc4 = 0; m_valid = 0;
    end else if (stall) begin
      // hold
    end else if (jump && m_valid) begin
      m_pc = {m_pc4[31:28], jump_index, 2'b00};
      m_instr = 0; m_valid = 0;
    end else begin
      m_instr = mem_f(m_pc);
      m_pc    = m_pc + 32'd4;
      m_pc4   = m_pc;
      m_valid = 1;
      m_count = m_count + 32'd1;
    end
  end

  // Compare every cycle, mid-way between edges (inputs change at negedge+1).
  bit cmp_en = 0;
  always @(negedge clk) begin
    if (cmp_en) begin
      check("imem_addr", imem_addr, m_pc);
      check("ifid_instr", ifid_instr, m_instr);
      check("ifid_valid", {31'd0, ifid_valid}, {31'd0, m_valid});
      check("op", {26'd0, op}, {26'd0, m_instr[31:26]});
      check("fetch_count", fetch_count, m_count);
      check("flush_idex", {31'd0, flush_idex}, {31'd0, branch_taken});
      if (m_valid) check("ifid_pc4", ifid_pc4, m_pc4);
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic idle();
    stall = 0; jump = 0; branch_taken = 0; jump_index = 0; branch_target = 0;
  endtask

  initial begin
    reset = 1;
    idle();
    tick(); tick();
    check("rst_pc", imem_addr, 32'h3000);
    check("rst_valid", {31'd0, ifid_valid}, 32'd0);
    check("rst_count", fetch_count, 32'd0);
    check("rst_pc4", ifid_pc4, 32'd0);
    cmp_en = 1;
    reset = 0;

    // Sequential fetch from reset
    tick();
    check("e1_instr", ifid_instr, 32'h3401_0005);
    check("e1_pc4", ifid_pc4, 32'h3004);
    check("e1_op", {26'd0, op}, 32'h0000_000D);
    check("e1_valid", {31'd0, ifid_valid}, 32'd1);
    tick();
    check("e2_instr", ifid_instr, 32'h8C22_0000);
    check("e2_addr", imem_addr, 32'h3008);
    check("e2_count", fetch_count, 32'd2);

    // Two-cycle stall
    stall = 1;
    for (int i = 0; i < 2; i++) begin
      tick();
      check("stall_addr", imem_addr, 32'h3008);
      check("stall_instr", ifid_instr, 32'h8C22_0000);
      check("stall_count", fetch_count, 32'd2);
    end
    stall = 0;
    tick();
    check("unstall_instr", ifid_instr, mem_f(32'h3008));
    check("unstall_pc4", ifid_pc4, 32'h300C);

    // Jump resolved in ID
    tick();
    check("jmp_in_ifid", ifid_instr, 32'h0800_0C10);
    check("jmp_pc4", ifid_pc4, 32'h3010);
    jump = 1; jump_index = 26'h0000C10;
    tick();
    check("jmp_pc", imem_addr, 32'h3040);
    check("jmp_valid", {31'd0, ifid_valid}, 32'd0);
    check("jmp_count", fetch_count, 32'd4);
    idle();
    tick();
    check("jmp_tgt_instr", ifid_instr, mem_f(32'h3040));
    check("jmp_tgt_pc4", ifid_pc4, 32'h3044);

    // Branch overrides stall and jump
    branch_taken = 1; branch_target = 32'h3100; stall = 1; jump = 1;
    #1;
    check("br_flush", {31'd0, flush_idex}, 32'd1);
    tick();
    check("br_pc", imem_addr, 32'h3100);
    check("br_valid", {31'd0, ifid_valid}, 32'd0);
    check("br_pc4", ifid_pc4, 32'd0);
    idle();

    // Async reset mid-cycle while stalled at 3020
    branch_taken = 1; branch_target = 32'h3020;
    tick();
    idle();
    stall = 1;
    check("pre_rst_pc", imem_addr, 32'h3020);
    #2 reset = 1;
    #1;
    check("arst_pc", imem_addr, 32'h3000);
    check("arst_valid", {31'd0, ifid_valid}, 32'd0);
    check("arst_instr", ifid_instr, 32'd0);
    check("arst_count", fetch_count, 32'd0);
    tick();
    reset = 0; stall = 0;
    tick();
    check("rst_resume_instr", ifid_instr, 32'h3401_0005);
    check("rst_resume_pc4", ifid_pc4, 32'h3004);

    // PC wrap
    branch_taken = 1; branch_target = 32'hFFFF_FFFF;
    tick();
    idle();
    check("wrap_pc", imem_addr, 32'hFFFF_FFFC);
    tick();
    check("wrap_pc4", ifid_pc4, 32'h0);
    check("wrap_addr", imem_addr, 32'h0);
    check("wrap_valid", {31'd0, ifid_valid}, 32'd1);

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      stall         = ($urandom_range(0, 5) == 0);
      jump          = ($urandom_range(0, 4) == 0);
      jump_index    = 26'($urandom);
      branch_taken  = ($urandom_range(0, 9) == 0);
      branch_target = $urandom;
      if ($urandom_range(0, 99) == 0) begin
        #2 reset = 1;
        #1 reset = 0;
      end
      tick();
    end

    idle();
    tick();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
